// File: rtl/memprep_lsu_if.sv
// Data-bus interface between the MEMPREP load/store unit and the data memory.
interface memprep_lsu_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/memprep_lsu.sv
// MEMPREP stage load/store unit: issues data-bus requests, stalls the pipe
// until the response, and registers the writeback payload.
module memprep_lsu (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 invalid_MEMPREP,
    input  logic                 regfile_we_MEMPREP,
    input  logic                 lsu_we_MEMPREP,
    input  logic                 lsu_sign_extend_MEMPREP,
    input  logic [3:0]           rd_MEMPREP,
    input  logic [1:0]           rd_data_sel_MEMPREP,
    input  logic [1:0]           data_width_MEMPREP,
    input  logic [31:0]          pc4_MEMPREP,
    input  logic [31:0]          alu_result_MEMPREP,
    input  logic [31:0]          rs2_data_MEMPREP,
    memprep_lsu_if.master        mem,
    output logic                 stall_MEMPREP,
    output logic                 misaligned_MEMPREP,
    output logic [3:0]           rd_WB,
    output logic                 regfile_we_WB,
    output logic [31:0]          rd_data_WB
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned RW   = 4;

    typedef enum logic [1:0] {IDLE, REQ, RSP} state_e;

    state_e          state_q, state_d;
    logic [RW-1:0]   rd_wb_q, rd_wb_d;
    logic            we_wb_q, we_wb_d;
    logic [XLEN-1:0] data_wb_q, data_wb_d;

    logic            access_c, misaligned_c, aligned_c, req_c, stall_c;
    logic [1:0]      off_c;
    logic [7:0]      lane_b_c;
    logic [15:0]     lane_h_c;
    logic [XLEN-1:0] load_c;

    // Access decode and alignment check; width 11 behaves as word.
    always_comb begin
        off_c    = alu_result_MEMPREP[1:0];
        access_c = !invalid_MEMPREP && (lsu_we_MEMPREP || rd_data_sel_MEMPREP == 2'b01);
        unique case (data_width_MEMPREP)
            2'b00:   misaligned_c = 1'b0;
            2'b01:   misaligned_c = access_c && off_c[0];
            default: misaligned_c = access_c && (off_c != 2'b00);
        endcase
        aligned_c = access_c && !misaligned_c;
    end

    always_comb begin
        state_d = state_q;
        req_c   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (aligned_c) begin
                    req_c   = 1'b1;
                    state_d = mem.mem_gnt ? RSP : REQ;
                end
            end
            REQ: begin
                req_c = 1'b1;
                if (mem.mem_gnt) state_d = RSP;
            end
            RSP: begin
                if (mem.mem_rvalid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus-facing and stall outputs are combinational; reset forces them low at once.
    always_comb begin
        stall_c            = aligned_c && !(state_q == RSP && mem.mem_rvalid);
        mem.mem_req        = req_c && !rst;
        stall_MEMPREP      = stall_c && !rst;
        misaligned_MEMPREP = misaligned_c && !rst;
        mem.mem_addr       = {alu_result_MEMPREP[31:2], 2'b00};
        mem.mem_we         = lsu_we_MEMPREP;
        unique case (data_width_MEMPREP)
            2'b00: begin
                mem.mem_wdata = {4{rs2_data_MEMPREP[7:0]}};
                mem.mem_wstrb = 4'(4'b0001 << off_c);
            end
            2'b01: begin
                mem.mem_wdata = {2{rs2_data_MEMPREP[15:0]}};
                mem.mem_wstrb = 4'(4'b0011 << off_c);
            end
            default: begin
                mem.mem_wdata = rs2_data_MEMPREP;
                mem.mem_wstrb = 4'b1111;
            end
        endcase
        if (!lsu_we_MEMPREP) mem.mem_wstrb = 4'b0000;
    end

    // Load lane extraction from the response word.
    always_comb begin
        lane_b_c = 8'(mem.mem_rdata >> {off_c, 3'b000});
        lane_h_c = 16'(mem.mem_rdata >> {off_c[1], 4'b0000});
        unique case (data_width_MEMPREP)
            2'b00:   load_c = lsu_sign_extend_MEMPREP ? {{24{lane_b_c[7]}}, lane_b_c}
                                                      : {24'b0, lane_b_c};
            2'b01:   load_c = lsu_sign_extend_MEMPREP ? {{16{lane_h_c[15]}}, lane_h_c}
                                                      : {16'b0, lane_h_c};
            default: load_c = mem.mem_rdata;
        endcase
    end

    always_comb begin
        rd_wb_d = rd_MEMPREP;
        we_wb_d = regfile_we_MEMPREP && !invalid_MEMPREP && !stall_c && !misaligned_c;
        unique case (rd_data_sel_MEMPREP)
            2'b01:   data_wb_d = load_c;
            2'b10:   data_wb_d = pc4_MEMPREP;
            default: data_wb_d = alu_result_MEMPREP;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rd_wb_q   <= '0;
            we_wb_q   <= 1'b0;
            data_wb_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_wb_q   <= rd_wb_d;
            we_wb_q   <= we_wb_d;
            data_wb_q <= data_wb_d;
        end
    end

    assign rd_WB         = rd_wb_q;
    assign regfile_we_WB = we_wb_q;
    assign rd_data_WB    = data_wb_q;
endmodule

// File: tb/tb_memprep_lsu.sv
// Randomized and directed bench for memprep_lsu against a behavioural model.
module tb_memprep_lsu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inv, rwe, lwe, sx;
    logic [3:0]  rd;
    logic [1:0]  sel, wid;
    logic [31:0] pc4, alu, rs2;
    logic        stall, mis, wb_we;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        int          stalls;
        bit          unstable;
        logic        req0, we0, mis0, wbwe;
        logic [31:0] addr0, wdata0, wbdata;
        logic [3:0]  wstrb0, wbrd;
    } obs_t;

    always #5 clk = ~clk;

    memprep_lsu_if bus();

    memprep_lsu dut (
        .clk(clk), .rst(rst),
        .invalid_MEMPREP(inv), .regfile_we_MEMPREP(rwe), .lsu_we_MEMPREP(lwe),
        .lsu_sign_extend_MEMPREP(sx), .rd_MEMPREP(rd), .rd_data_sel_MEMPREP(sel),
        .data_width_MEMPREP(wid), .pc4_MEMPREP(pc4), .alu_result_MEMPREP(alu),
        .rs2_data_MEMPREP(rs2), .mem(bus), .stall_MEMPREP(stall),
        .misaligned_MEMPREP(mis), .rd_WB(wb_rd), .regfile_we_WB(wb_we), .rd_data_WB(wb_data)
    );

    function automatic int nbytes(input logic [1:0] w);
        return (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] d, input int off, input int n, input logic s);
        logic [63:0] mask, v;
        mask = (64'd1 << (8 * n)) - 64'd1;
        v = ({32'd0, d} >> (8 * off)) & mask;
        if (s && v[8 * n - 1]) v = v | ~mask;
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] v, input int n);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8 * i +: 8] = 8'(v >> (8 * (i % n)));
        return r;
    endfunction

    // Presents one instruction, serves the bus with the given delays, returns what was seen.
    task automatic run_op(input logic i_inv, i_rwe, i_lwe, i_sx, input logic [3:0] i_rd,
                          input logic [1:0] i_sel, i_wid, input logic [31:0] i_pc4, i_addr,
                          i_rs2, i_rdata, input int gdly, rdly, output obs_t o);
        int gcyc;
        bit granted, done, tmo;
        @(negedge clk);
        inv = i_inv; rwe = i_rwe; lwe = i_lwe; sx = i_sx; rd = i_rd; sel = i_sel;
        wid = i_wid; pc4 = i_pc4; alu = i_addr; rs2 = i_rs2; bus.mem_rdata = i_rdata;
        o = '{default: 0};
        gcyc = 0; granted = 0; tmo = 1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            bus.mem_gnt    = (!granted && cyc == gdly);
            bus.mem_rvalid = (granted && cyc == gcyc + rdly);
            #1;
            if (cyc == 0) begin
                o.req0 = bus.mem_req; o.we0 = bus.mem_we; o.addr0 = bus.mem_addr;
                o.wdata0 = bus.mem_wdata; o.wstrb0 = bus.mem_wstrb; o.mis0 = mis;
            end else if (bus.mem_req && (bus.mem_addr !== o.addr0 || bus.mem_we !== o.we0 ||
                         bus.mem_wdata !== o.wdata0 || bus.mem_wstrb !== o.wstrb0)) begin
                o.unstable = 1;
            end
            if (stall === 1'b1) o.stalls++;
            done = (stall !== 1'b1);
            if (bus.mem_gnt && bus.mem_req) begin granted = 1; gcyc = cyc; end
            @(posedge clk); #1;
            if (done) begin
                o.wbwe = wb_we; o.wbrd = wb_rd; o.wbdata = wb_data; tmo = 0;
                break;
            end
            @(negedge clk);
        end
        inv = 1'b1; bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
        checks++;
        if (tmo) begin failures++; $display("FAIL op_timeout: stall still high after 40 cycles"); end
    endtask

    task automatic test_reset();
        rst = 1'b1; inv = 1'b0; rwe = 1'b1; lwe = 1'b0; sx = 1'b0; rd = 4'd9; sel = 2'b01;
        wid = 2'b10; pc4 = 32'h4; alu = 32'h100; rs2 = 32'h0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h5555_AAAA;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b want 0", bus.mem_req); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b want 0", stall); end
        checks++; if (wb_we !== 1'b0) begin failures++; $display("FAIL reset_wb_we: got %b want 0", wb_we); end
        checks++; if (wb_rd !== 4'd0) begin failures++; $display("FAIL reset_rd: got %h want 0", wb_rd); end
        checks++; if (wb_data !== 32'd0) begin failures++; $display("FAIL reset_data: got %h want 0", wb_data); end
        alu = 32'h101; #1;
        checks++; if (mis !== 1'b0) begin failures++; $display("FAIL reset_mis: got %b want 0", mis); end
        @(negedge clk); inv = 1'b1; rst = 1'b0;
    endtask

    task automatic test_load_word();
        obs_t o;
        run_op(0, 1, 0, 0, 4'd5, 2'b01, 2'b10, 32'h44, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1, o);
        checks++; if (o.stalls != 1) begin failures++; $display("FAIL lw_stalls: got %0d want 1", o.stalls); end
        checks++; if (o.req0 !== 1'b1 || o.addr0 !== 32'h100 || o.we0 !== 1'b0 || o.wstrb0 !== 4'b0000) begin
            failures++; $display("FAIL lw_bus: got req=%b addr=%h we=%b strb=%b want 1 100 0 0000", o.req0, o.addr0, o.we0, o.wstrb0); end
        checks++; if (o.wbwe !== 1'b1 || o.wbdata !== 32'hDEADBEEF || o.wbrd !== 4'd5) begin
            failures++; $display("FAIL lw_wb: got we=%b data=%h rd=%h want 1 deadbeef 5", o.wbwe, o.wbdata, o.wbrd); end
    endtask

    task automatic test_signed_byte();
        obs_t o;
        run_op(0, 1, 0, 1, 4'd3, 2'b01, 2'b00, 32'h0, 32'h103, 32'h0, 32'h80FFFFFF, 0, 1, o);
        checks++; if (o.wbwe !== 1'b1 || o.wbdata !== 32'hFFFFFF80) begin
            failures++; $display("FAIL lb_signed: got we=%b data=%h want 1 ffffff80", o.wbwe, o.wbdata); end
        run_op(0, 1, 0, 0, 4'd3, 2'b01, 2'b00, 32'h0, 32'h103, 32'h0, 32'h80FFFFFF, 1, 1, o);
        checks++; if (o.wbwe !== 1'b1 || o.wbdata !== 32'h00000080) begin
            failures++; $display("FAIL lbu_zero: got we=%b data=%h want 1 00000080", o.wbwe, o.wbdata); end
    endtask

    task automatic test_store_half();
        obs_t o;
        run_op(0, 0, 1, 0, 4'd0, 2'b00, 2'b01, 32'h0, 32'h202, 32'h1234ABCD, 32'h0, 0, 1, o);
        checks++; if (o.wstrb0 !== 4'b1100 || o.wdata0 !== 32'hABCDABCD || o.we0 !== 1'b1 || o.addr0 !== 32'h200) begin
            failures++; $display("FAIL sh_bus: got strb=%b wdata=%h we=%b addr=%h want 1100 abcdabcd 1 200",
                                 o.wstrb0, o.wdata0, o.we0, o.addr0); end
        checks++; if (o.wbwe !== 1'b0 || o.stalls != 1) begin
            failures++; $display("FAIL sh_wb: got we=%b stalls=%0d want 0 1", o.wbwe, o.stalls); end
    endtask

    task automatic test_gnt_wait();
        obs_t o;
        run_op(0, 1, 0, 0, 4'd12, 2'b01, 2'b10, 32'h0, 32'h3F0, 32'h0, 32'hCAFEF00D, 3, 2, o);
        checks++; if (o.stalls != 5) begin failures++; $display("FAIL wait_stalls: got %0d want 5", o.stalls); end
        checks++; if (o.unstable) begin failures++; $display("FAIL wait_stable: got unstable bus want stable"); end
        checks++; if (o.wbwe !== 1'b1 || o.wbdata !== 32'hCAFEF00D || o.wbrd !== 4'd12) begin
            failures++; $display("FAIL wait_wb: got we=%b data=%h rd=%h want 1 cafef00d c", o.wbwe, o.wbdata, o.wbrd); end
    endtask

    task automatic test_misaligned();
        obs_t o;
        run_op(0, 1, 0, 0, 4'd6, 2'b01, 2'b10, 32'h0, 32'h101, 32'h0, 32'h11111111, 0, 1, o);
        checks++; if (o.req0 !== 1'b0 || o.mis0 !== 1'b1 || o.stalls != 0) begin
            failures++; $display("FAIL mis_first: got req=%b mis=%b stalls=%0d want 0 1 0", o.req0, o.mis0, o.stalls); end
        checks++; if (o.wbwe !== 1'b0) begin failures++; $display("FAIL mis_wb: got %b want 0", o.wbwe); end
        #1;
        checks++; if (mis !== 1'b0) begin failures++; $display("FAIL mis_pulse: got %b want 0", mis); end
    endtask

    task automatic test_idle_ignore();
        obs_t o;
        @(negedge clk); inv = 1'b1; rwe = 1'b1; bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b1;
        @(posedge clk); @(negedge clk); #1;
        checks++; if (bus.mem_req !== 1'b0 || stall !== 1'b0 || wb_we !== 1'b0) begin
            failures++; $display("FAIL idle_ignore: got req=%b stall=%b we=%b want 0 0 0", bus.mem_req, stall, wb_we); end
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
        run_op(0, 1, 0, 0, 4'd2, 2'b01, 2'b10, 32'h0, 32'h80, 32'h0, 32'h0BADF00D, 1, 1, o);
        checks++; if (o.stalls != 2 || o.wbdata !== 32'h0BADF00D) begin
            failures++; $display("FAIL idle_after: got stalls=%0d data=%h want 2 0badf00d", o.stalls, o.wbdata); end
    endtask

    task automatic test_reset_in_rsp();
        obs_t o;
        @(negedge clk);
        inv = 1'b0; rwe = 1'b1; lwe = 1'b0; sx = 1'b0; rd = 4'd7; sel = 2'b01; wid = 2'b10;
        alu = 32'h100; bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b0;
        @(posedge clk); @(negedge clk); bus.mem_gnt = 1'b0; #1;
        checks++; if (stall !== 1'b1 || bus.mem_req !== 1'b0) begin
            failures++; $display("FAIL rsp_state: got stall=%b req=%b want 1 0", stall, bus.mem_req); end
        rst = 1'b1; #1;
        checks++; if (stall !== 1'b0 || bus.mem_req !== 1'b0 || wb_rd !== 4'd0 || wb_data !== 32'd0 || wb_we !== 1'b0) begin
            failures++; $display("FAIL rst_async: got stall=%b req=%b rd=%h data=%h we=%b want all 0",
                                 stall, bus.mem_req, wb_rd, wb_data, wb_we); end
        inv = 1'b1;
        @(negedge clk); rst = 1'b0; bus.mem_rvalid = 1'b1;
        @(posedge clk); #1;
        checks++; if (wb_we !== 1'b0) begin failures++; $display("FAIL late_rvalid: got we=%b want 0", wb_we); end
        @(negedge clk); bus.mem_rvalid = 1'b0;
        run_op(0, 1, 0, 0, 4'd8, 2'b01, 2'b10, 32'h0, 32'h104, 32'h0, 32'h76543210, 0, 1, o);
        checks++; if (o.stalls != 1 || o.wbdata !== 32'h76543210) begin
            failures++; $display("FAIL post_rst_load: got stalls=%0d data=%h want 1 76543210", o.stalls, o.wbdata); end
    endtask

    task automatic test_random();
        obs_t o;
        for (int k = 0; k < 60; k++) begin
            int kind, n, off, g, r, exp_st;
            logic t_inv, t_rwe, t_lwe, t_sx, acc, misal, ok_acc, exp_we;
            logic [1:0] t_sel, t_wid;
            logic [3:0] t_rd, exp_strb;
            logic [31:0] t_pc4, t_addr, t_rs2, t_rdata, exp_data;
            kind = $urandom_range(0, 2);
            t_inv = ($urandom_range(0, 9) == 0); t_sx = 1'($urandom); t_rd = 4'($urandom);
            t_wid = 2'($urandom); t_pc4 = $urandom; t_addr = $urandom; t_rs2 = $urandom; t_rdata = $urandom;
            if ($urandom_range(0, 2) != 0) t_addr[1:0] = 2'b00;
            g = $urandom_range(0, 3); r = $urandom_range(1, 3);
            case (kind)
                0: begin t_lwe = 0; t_rwe = 1'($urandom); t_sel = ($urandom_range(0, 2) == 0) ? 2'b10 : 2'($urandom_range(0, 1) * 3); end
                1: begin t_lwe = 0; t_rwe = ($urandom_range(0, 4) != 0); t_sel = 2'b01; end
                default: begin t_lwe = 1; t_rwe = 0; t_sel = 2'b00; end
            endcase
            n = nbytes(t_wid); off = int'(t_addr[1:0]);
            acc = !t_inv && (t_lwe || t_sel == 2'b01);
            misal = acc && (off % n != 0);
            ok_acc = acc && !misal;
            exp_st = ok_acc ? g + r : 0;
            exp_we = t_rwe && !t_inv && !misal;
            exp_strb = t_lwe ? 4'(((1 << n) - 1) << off) : 4'b0000;
            exp_data = (t_sel == 2'b01) ? model_load(t_rdata, off, n, t_sx) : (t_sel == 2'b10) ? t_pc4 : t_addr;
            run_op(t_inv, t_rwe, t_lwe, t_sx, t_rd, t_sel, t_wid, t_pc4, t_addr, t_rs2, t_rdata, g, r, o);
            checks++; if (o.stalls != exp_st) begin failures++; $display("FAIL rnd%0d_stalls: got %0d want %0d", k, o.stalls, exp_st); end
            checks++; if (o.req0 !== ok_acc || o.mis0 !== misal) begin
                failures++; $display("FAIL rnd%0d_req_mis: got %b %b want %b %b", k, o.req0, o.mis0, ok_acc, misal); end
            checks++; if (o.wbwe !== exp_we || o.wbrd !== t_rd) begin
                failures++; $display("FAIL rnd%0d_wb_ctl: got we=%b rd=%h want %b %h", k, o.wbwe, o.wbrd, exp_we, t_rd); end
            if (exp_we) begin
                checks++; if (o.wbdata !== exp_data) begin
                    failures++; $display("FAIL rnd%0d_wb_data: got %h want %h", k, o.wbdata, exp_data); end
            end
            if (ok_acc) begin
                checks++; if (o.addr0 !== {t_addr[31:2], 2'b00} || o.we0 !== t_lwe || o.wstrb0 !== exp_strb || o.unstable) begin
                    failures++; $display("FAIL rnd%0d_bus: got addr=%h we=%b strb=%b unstable=%0d want %h %b %b 0",
                                         k, o.addr0, o.we0, o.wstrb0, o.unstable, {t_addr[31:2], 2'b00}, t_lwe, exp_strb); end
                if (t_lwe) begin
                    checks++; if (o.wdata0 !== model_wdata(t_rs2, n)) begin
                        failures++; $display("FAIL rnd%0d_wdata: got %h want %h", k, o.wdata0, model_wdata(t_rs2, n)); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_signed_byte();
        test_store_half();
        test_gnt_wait();
        test_misaligned();
        test_idle_ignore();
        test_reset_in_rsp();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
